// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES byte substitution (forward or inverse S-box) over a
// NUM_BYTES block, LANES bytes per clock through shared S-box lanes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data block, in_inverse mode
//   out_valid/out_ready output handshake; out_data substituted block

package sub_bytes_pkg;

    // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gf_mul(a, a);
        r  = sq;
        for (int i = 2; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

endpackage

// Forward S-box: inverse in GF(2^8), then affine transform.
module s_box
    import sub_bytes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] v;

    assign v   = gf_inv(a_i);
    assign y_o = v
               ^ {v[6:0], v[7]}
               ^ {v[5:0], v[7:6]}
               ^ {v[4:0], v[7:5]}
               ^ {v[3:0], v[7:4]}
               ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform, then GF(2^8) inverse.
module inv_s_box
    import sub_bytes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] u;

    assign u   = {a_i[6:0], a_i[7]}
               ^ {a_i[4:0], a_i[7:5]}
               ^ {a_i[1:0], a_i[7:2]}
               ^ 8'h05;
    assign y_o = gf_inv(u);
endmodule

module sub_bytes_engine #(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_inverse,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data
);

    localparam int DW    = 8 * NUM_BYTES;
    localparam int LW    = 8 * LANES;
    localparam int BEATS = NUM_BYTES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    if ((NUM_BYTES % LANES) != 0) begin : g_bad_cfg
        $error("sub_bytes_engine: LANES must divide NUM_BYTES");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            mode_q, mode_d;

    logic [LW-1:0]   top;
    logic [LW-1:0]   sub;
    logic [DW-1:0]   shifted;

    // The top LANES bytes are substituted each beat
    assign top = data_q[DW-1 -: LW];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] fwd_b;
        logic [7:0] inv_b;

        s_box u_fwd (
            .a_i (top[8*l +: 8]),
            .y_o (fwd_b)
        );

        inv_s_box u_inv (
            .a_i (top[8*l +: 8]),
            .y_o (inv_b)
        );

        assign sub[8*l +: 8] = mode_q ? inv_b : fwd_b;
    end

    // Rotate left by one lane group; after BEATS beats the byte
    // order is restored with every byte substituted.
    if (BEATS == 1) begin : g_one_beat
        assign shifted = sub;
    end else begin : g_multi_beat
        assign shifted = {data_q[DW-LW-1:0], sub};
    end

    assign in_ready  = (state_q == IDLE) ||
                       ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;

        unique case (state_q)
            IDLE: begin
            end
            BUSY: begin
                data_d = shifted;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance from IDLE, or back-to-back from DONE
        if (in_valid && in_ready) begin
            data_d  = in_data;
            mode_d  = in_inverse;
            cnt_d   = '0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: three configurations
// (4/1, 16/4, 16/16) share stimulus; one is selected for checking.

module tb_sub_bytes_engine;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_inverse;
    logic         out_ready;
    logic [127:0] in_data;

    logic         ir4, ov4;
    logic [31:0]  od4;
    logic         irm, ovm;
    logic [127:0] odm;
    logic         irw, ovw;
    logic [127:0] odw;

    int           sel;
    logic         t_in_ready;
    logic         t_out_valid;
    logic [127:0] t_out_data;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] sb[$];

    localparam logic [127:0] BLK_A = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] SUB_A = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SUB_B = 128'h638293c31bfc33f5c4eeacea4bc12816;

    sub_bytes_engine #(.NUM_BYTES(4), .LANES(1)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (ir4),
        .in_data    (in_data[31:0]),
        .in_inverse (in_inverse),
        .out_valid  (ov4),
        .out_ready  (out_ready),
        .out_data   (od4)
    );

    sub_bytes_engine #(.NUM_BYTES(16), .LANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (irm),
        .in_data    (in_data),
        .in_inverse (in_inverse),
        .out_valid  (ovm),
        .out_ready  (out_ready),
        .out_data   (odm)
    );

    sub_bytes_engine #(.NUM_BYTES(16), .LANES(16)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (irw),
        .in_data    (in_data),
        .in_inverse (in_inverse),
        .out_valid  (ovw),
        .out_ready  (out_ready),
        .out_data   (odw)
    );

    always_comb begin
        t_in_ready  = irm;
        t_out_valid = ovm;
        t_out_data  = odm;
        if (sel == 0) begin
            t_in_ready  = ir4;
            t_out_valid = ov4;
            t_out_data  = {96'b0, od4};
        end else if (sel == 2) begin
            t_in_ready  = irw;
            t_out_valid = ovw;
            t_out_data  = odw;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [127:0] d, input logic inv,
                        input logic [127:0] exp, input bit push);
        int n;
        n = 0;
        in_data    = d;
        in_inverse = inv;
        in_valid   = 1'b1;
        while (t_in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 128'(t_in_ready), 128'(1'b1));
        @(posedge clk);
        if (push) sb.push_back(exp);
        @(negedge clk);
        in_valid   = 1'b0;
        in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_inverse = 1'($urandom());
    endtask

    // start = edges already elapsed since acceptance at this negedge.
    task automatic recv(input string tag, input int lat,
                        input int start, input bit consume);
        int e;
        logic [127:0] exp;
        e = start;
        while (t_out_valid !== 1'b1 && e < 60) begin
            @(negedge clk);
            e++;
        end
        chk({tag, "_latency"}, 128'(e), 128'(lat));
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk({tag, "_data"}, t_out_data, exp);
        if (consume) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_drop"}, 128'(t_out_valid), 128'(1'b0));
        end
    endtask

    initial begin
        int done;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_inverse = 1'b0;
        out_ready  = 1'b1;
        in_data    = '0;
        sel        = 1;
        #1;
        chk("rst_ir4", 128'(ir4), 128'(1'b1));
        chk("rst_irm", 128'(irm), 128'(1'b1));
        chk("rst_irw", 128'(irw), 128'(1'b1));
        chk("rst_ovm", 128'(ovm), 128'(1'b0));
        chk("rst_odm", odm, 128'h0);
        chk("rst_od4", 128'(od4), 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 4 bytes, one lane
        sel = 0;
        send(128'h00102030, 1'b0, 128'h63cab704, 1'b1);
        recv("t1", 5, 1, 1'b1);

        // 16 bytes, four lanes, forward then inverse
        sel = 1;
        send(BLK_A, 1'b0, SUB_A, 1'b1);
        recv("t2_fwd", 5, 1, 1'b1);
        send(SUB_A, 1'b1, BLK_A, 1'b1);
        recv("t2_inv", 5, 1, 1'b1);

        // Backpressure, then back-to-back acceptance
        out_ready = 1'b0;
        send(BLK_A, 1'b0, SUB_A, 1'b1);
        recv("t3_first", 5, 1, 1'b0);
        repeat (10) begin
            @(negedge clk);
            chk("t3_hold_ov", 128'(t_out_valid), 128'(1'b1));
            chk("t3_hold_od", t_out_data, SUB_A);
            chk("t3_hold_ir", 128'(t_in_ready), 128'(1'b0));
        end
        out_ready = 1'b1;
        send({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b1);
        recv("t3_b2b", 5, 1, 1'b1);

        // All lanes: single BUSY cycle
        sel = 2;
        send(128'h0, 1'b0, {16{8'h63}}, 1'b1);
        recv("t4_fwd", 2, 1, 1'b1);
        send({16{8'h63}}, 1'b1, 128'h0, 1'b1);
        recv("t4_inv", 2, 1, 1'b1);

        // Reset in the second BUSY cycle
        sel = 1;
        send(SUB_A, 1'b0, 128'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_ov", 128'(t_out_valid), 128'(1'b0));
        chk("t5_ir", 128'(t_in_ready), 128'(1'b1));
        chk("t5_od", t_out_data, 128'h0);
        @(negedge clk);
        rst  = 1'b0;
        done = 0;
        repeat (8) begin
            @(negedge clk);
            if (t_out_valid) done++;
        end
        chk("t5_no_result", 128'(done), 128'h0);
        send({16{8'hed}}, 1'b1, {16{8'h53}}, 1'b1);
        recv("t5_after", 5, 1, 1'b1);

        // Inputs toggling during BUSY are ignored
        send(BLK_B, 1'b0, SUB_B, 1'b1);
        repeat (2) begin
            in_valid   = 1'b1;
            in_inverse = 1'b1;
            in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
        end
        in_valid = 1'b0;
        recv("t6", 5, 3, 1'b1);
        done = 0;
        repeat (10) begin
            @(negedge clk);
            if (t_out_valid) done++;
        end
        chk("t6_single", 128'(done), 128'h0);
        chk("sb_empty", 128'(sb.size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
